// File: rtl/ex_rr_scheduler_pkg.sv
// Shared definitions for the round-robin datapath scheduler:
// FSM state encodings and the stray-pulse counter ceiling.
package ex_rr_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  localparam int          STRAY_W   = 8;
  localparam logic [7:0]  STRAY_MAX = 8'hFF;

endpackage : ex_rr_scheduler_pkg

// File: rtl/ex_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index at
// or after ptr, searching upward with wrap-around. Emits one-hot grant,
// binary index and an any-request flag.
module ex_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // cand[k] is the requester index visited k steps after ptr.
  logic [IW-1:0] cand [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum = {1'b0, ptr} + (IW+1)'(gi);
      assign cand[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    end
  endgenerate

  // Scan from farthest to nearest so the nearest requester overrides.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[cand[j]]) begin
        any     = 1'b1;
        gnt_idx = cand[j];
      end
    end
    gnt[gnt_idx] = any;
  end

endmodule : ex_rr_arbiter

// File: rtl/ex_rr_scheduler.sv
// Round-robin scheduler sharing one datapath among N_REQ requesters.
// One request in flight at a time: accept, pulse ce, wait (with timeout),
// then hold a tagged response until the consumer takes it.
module ex_rr_scheduler
  import ex_rr_scheduler_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int DW      = 32,
  parameter  int TIMEOUT = 15,
  localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*DW-1:0]    req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   dp_ce,
  output logic [DW-1:0]          dp_data_in,
  input  logic                   dp_data_valid,
  input  logic signed [DW-1:0]   dp_data_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic signed [DW-1:0]   rsp_data,
  output logic [IW-1:0]          rsp_id,
  output logic                   rsp_err,
  output logic [STRAY_W-1:0]     stray_cnt
);

  localparam logic [7:0]    WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(N_REQ - 1);

  sched_state_e          state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]         op_q, op_d;
  logic [IW-1:0]         id_q, id_d;
  logic signed [DW-1:0]  res_q, res_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [STRAY_W-1:0]    stray_q, stray_d;

  logic [N_REQ-1:0]      arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;

  ex_rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Next-state, register updates and the combinational accept pulse.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    op_d      = op_q;
    id_d      = id_q;
    res_d     = res_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    stray_d   = stray_q;
    req_ready = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready = arb_gnt;
          id_d      = arb_idx;
          for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) op_d = req_data[i*DW +: DW];
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A result arriving on the last wait cycle still beats the timeout.
        if (dp_data_valid) begin
          res_d   = dp_data_out;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == WAIT_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any datapath result outside WAIT has no owner.
    if (dp_data_valid && (state_q != ST_WAIT) && (stray_q != STRAY_MAX)) begin
      stray_d = stray_q + 1'b1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      op_q     <= '0;
      id_q     <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      stray_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      id_q     <= id_d;
      res_q    <= res_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      stray_q  <= stray_d;
    end
  end

  assign dp_ce      = (state_q == ST_ISSUE);
  assign dp_data_in = op_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data   = res_q;
  assign rsp_id     = id_q;
  assign rsp_err    = err_q;
  assign stray_cnt  = stray_q;

endmodule : ex_rr_scheduler

// File: tb/tb_ex_rr_scheduler.sv
// Directed bench for ex_rr_scheduler: a transaction table plus hand-written
// stray/reset sequences.
module tb_ex_rr_scheduler;

  localparam int N_REQ   = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*DW-1:0]   req_data;
  logic [N_REQ-1:0]      req_ready;
  logic                  dp_ce;
  logic [DW-1:0]         dp_data_in;
  logic                  dp_data_valid;
  logic signed [DW-1:0]  dp_data_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic signed [DW-1:0]  rsp_data;
  logic [1:0]            rsp_id;
  logic                  rsp_err;
  logic [7:0]            stray_cnt;

  int checks = 0;
  int errors = 0;

  ex_rr_scheduler #(.N_REQ(N_REQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .dp_ce         (dp_ce),
    .dp_data_in    (dp_data_in),
    .dp_data_valid (dp_data_valid),
    .dp_data_out   (dp_data_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_id        (rsp_id),
    .rsp_err       (rsp_err),
    .stray_cnt     (stray_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_before;
    logic [3:0]  rv;
    int          lat;       // cycles from ce to data_valid; -1 = never
    logic [31:0] res;
    int          bp;        // cycles rsp_ready is held low
    bit          keep;      // keep req_valid asserted after grant
    int          g;         // expected granted index
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t        tbl [NV];
  logic [31:0] ops [N_REQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge
  // right after the response handshake.
  task automatic run_txn(input int n, input vec_t v);
    int c;
    int exp_rise;
    logic [3:0] exp_gnt;
    exp_gnt  = 4'(1 << v.g);
    exp_rise = (v.lat > 0) ? 2 + v.lat : 2 + TIMEOUT;
    req_valid = v.rv;
    #1;
    check($sformatf("t%0d req_ready@T0", n), 32'(req_ready), 32'(exp_gnt));
    @(negedge clk);
    check($sformatf("t%0d dp_ce@T0+1", n), 32'(dp_ce), 32'd1);
    check($sformatf("t%0d dp_data_in", n), dp_data_in, ops[v.g]);
    if (!v.keep) req_valid = '0;
    c = 1;
    while (rsp_valid !== 1'b1 && c < 64) begin
      dp_data_valid = (v.lat > 0 && c == 1 + v.lat);
      dp_data_out   = v.res;
      @(negedge clk);
      c++;
    end
    dp_data_valid = 1'b0;
    check($sformatf("t%0d rsp_valid rise cycle", n), 32'(c), 32'(exp_rise));
    for (int k = 0; k <= v.bp; k++) begin
      check($sformatf("t%0d rsp_data", n), rsp_data, v.exp_data);
      check($sformatf("t%0d rsp_id", n), 32'(rsp_id), 32'(v.g));
      check($sformatf("t%0d rsp_err", n), 32'(rsp_err), 32'(v.exp_err));
      if (k > 0) check($sformatf("t%0d req_ready in RESP", n), 32'(req_ready), 32'd0);
      if (k < v.bp) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("t%0d rsp_valid after handshake", n), 32'(rsp_valid), 32'd0);
    $display("txn %0d: rv=%b grant=%0d data=0x%08h err=%0d", n, v.rv, v.g, v.exp_data, v.exp_err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; dp_data_valid = 1'b0;
    dp_data_out = '0; rsp_ready = 1'b0;

    ops[0] = 32'hAAAA_0000; ops[1] = 32'h0000_0010;
    ops[2] = 32'h1234_5678; ops[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < N_REQ; i++) req_data[i*DW +: DW] = ops[i];

    //            rst rv      lat res            bp keep g  exp_data       err
    tbl[0]  = '{1'b0, 4'b0010, 1, 32'hFFFF_FFFB, 0, 1'b0, 1, 32'hFFFF_FFFB, 1'b0};
    tbl[1]  = '{1'b1, 4'b1111, 1, 32'h1111_1111, 0, 1'b1, 0, 32'h1111_1111, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 2, 32'h2222_2222, 0, 1'b1, 1, 32'h2222_2222, 1'b0};
    tbl[3]  = '{1'b0, 4'b1111, 3, 32'h3333_3333, 0, 1'b1, 2, 32'h3333_3333, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, 1, 32'h4444_4444, 0, 1'b1, 3, 32'h4444_4444, 1'b0};
    tbl[5]  = '{1'b0, 4'b1111, 2, 32'h5555_5555, 0, 1'b1, 0, 32'h5555_5555, 1'b0};
    tbl[6]  = '{1'b0, 4'b1111, 3, 32'h6666_6666, 0, 1'b1, 1, 32'h6666_6666, 1'b0};
    tbl[7]  = '{1'b0, 4'b1111, 1, 32'h7777_7777, 0, 1'b1, 2, 32'h7777_7777, 1'b0};
    tbl[8]  = '{1'b0, 4'b1111, 4, 32'h8888_8888, 0, 1'b1, 3, 32'h8888_8888, 1'b0};
    tbl[9]  = '{1'b0, 4'b1111,-1, 32'hCAFE_F00D, 0, 1'b1, 0, 32'h0000_0000, 1'b1};
    tbl[10] = '{1'b0, 4'b1111, 2, 32'h7FFF_FFFF, 5, 1'b1, 1, 32'h7FFF_FFFF, 1'b0};
    tbl[11] = '{1'b0, 4'b1001, 1, 32'h8000_0000, 0, 1'b0, 3, 32'h8000_0000, 1'b0};
    tbl[12] = '{1'b0, 4'b0110, 3, 32'h0000_0001, 3, 1'b1, 1, 32'h0000_0001, 1'b0};
    tbl[13] = '{1'b0, 4'b0100, 1, 32'h0BAD_CAFE, 0, 1'b0, 2, 32'h0BAD_CAFE, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset dp_ce", 32'(dp_ce), 32'd0);
    check("reset dp_data_in", dp_data_in, 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset rsp_id", 32'(rsp_id), 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset stray_cnt", 32'(stray_cnt), 32'd0);
    @(negedge clk);

    for (int n = 0; n < NV; n++) begin
      if (tbl[n].rst_before) begin
        req_valid = '0;
        do_reset();
      end
      run_txn(n, tbl[n]);
    end
    req_valid = '0;

    // Stray pulses while idle.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      dp_data_valid = 1'b1;
      @(negedge clk);
      dp_data_valid = 1'b0;
      @(negedge clk);
    end
    check("stray after 3 idle pulses", 32'(stray_cnt), 32'd3);
    $display("stray: 3 idle pulses -> stray_cnt=%0d", stray_cnt);

    // Reset while waiting, then a late datapath result.
    req_valid = 4'b0001;
    @(negedge clk);                 // accepted
    req_valid = '0;
    check("rst-seq dp_ce", 32'(dp_ce), 32'd1);
    @(negedge clk);                 // WAIT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst-seq stray cleared", 32'(stray_cnt), 32'd0);
    dp_data_valid = 1'b1;
    dp_data_out   = 32'h1234_0000;
    @(negedge clk);
    dp_data_valid = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 6; k++) begin
        if (rsp_valid === 1'b1) seen++;
        @(negedge clk);
      end
      check("rst-seq no response", 32'(seen), 32'd0);
    end
    check("rst-seq late result is stray", 32'(stray_cnt), 32'd1);
    $display("reset in WAIT: late result -> stray_cnt=%0d", stray_cnt);

    // Saturation of the stray counter.
    do_reset();
    dp_data_valid = 1'b1;
    repeat (260) @(negedge clk);
    dp_data_valid = 1'b0;
    check("stray saturates", 32'(stray_cnt), 32'd255);
    $display("stray: 260 pulses -> stray_cnt=%0d", stray_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ex_rr_scheduler
